ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte at a time to the keyboard (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) over the same PS2_CLK/PS2_DAT pair that key_driver receives on. It sits beside key_driver under main, drives both lines open-drain, and raises `rx_inhibit` so the receiver ignores line activity while a host frame is in progress. It reports the device ACK, NACK or timeout to the CPU-side requester.

---
 rtl/ps2_host_tx_pkg.sv | 23 ++
 rtl/ps2_host_tx_line_sync.sv | 43 ++++
 rtl/ps2_host_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: the FSM state type and the
// microsecond-to-cycle conversion used to size every timer in the block.
// key_driver can import this too when it needs to know about rx_inhibit.
package ps2_tx_state_t;

  // Transmit FSM states, in the order a normal frame walks through them.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    TX,
    ACK,
    WAIT_IDLE
  } t;

  // Whole cycles per microsecond times the duration. The integer divide
  // happens first, so a non-integral MHz clock rounds its rate down.
  function automatic int unsigned usToCyc(input int unsigned clkHz,
                                          input int unsigned us);
    return (clkHz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for the raw PS2_CLK / PS2_DAT pins plus a
// falling-edge pulse on the synchronized clock. Both lines idle high on
// the bus, so every flop resets to 1. A line held low through reset then
// only produces a single edge pulse once reset is released.
// Shared with key_driver so both sides see the bus with identical latency.
module ps2_line_sync (
  input  logic clk_i,
  input  logic resetN_i,
  input  logic ps2Clk_i,
  input  logic ps2Dat_i,
  output logic clkSync_o,
  output logic datSync_o,
  output logic clkFall_o
);

  logic clkMeta_q;
  logic clkSync_q;
  logic clkPrev_q;
  logic datMeta_q;
  logic datSync_q;

  // Resynchronize both pins and keep one cycle of clock history for edge detection.
  always_ff @(posedge clk_i) begin
    if (!resetN_i) begin
      clkMeta_q <= 1'b1;
      clkSync_q <= 1'b1;
      clkPrev_q <= 1'b1;
      datMeta_q <= 1'b1;
      datSync_q <= 1'b1;
    end else begin
      clkMeta_q <= ps2Clk_i;
      clkSync_q <= clkMeta_q;
      clkPrev_q <= clkSync_q;
      datMeta_q <= ps2Dat_i;
      datSync_q <= datMeta_q;
    end
  end

  assign clkSync_o = clkSync_q;
  assign datSync_o = datSync_q;
  assign clkFall_o = clkPrev_q & ~clkSync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte per request over
// the shared PS2_CLK/PS2_DAT pair. It drives the lines open-drain through
// the two *_oe outputs. The tri-state buffers live in main.
// While a frame is in flight rx_inhibit tells key_driver to ignore the bus.
// Every request ends with exactly one of tx_done, tx_nack or tx_timeout.
module ps2_host_tx
  import ps2_tx_state_t::*;
#(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned EDGE_TIMEOUT_US  = 2000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_nack,
  output logic       tx_timeout,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INHIBIT_CYC       = usToCyc(CLK_HZ, INHIBIT_US);
  localparam int unsigned START_CYC         = usToCyc(CLK_HZ, 1);
  localparam int unsigned START_TIMEOUT_CYC = usToCyc(CLK_HZ, START_TIMEOUT_US);
  localparam int unsigned EDGE_TIMEOUT_CYC  = usToCyc(CLK_HZ, EDGE_TIMEOUT_US);

  // The phase counter times INHIBIT and START. The timeout counter is
  // sized for the longest wait, the one for the device's first edge.
  localparam int PH_W  = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W = $clog2(START_TIMEOUT_CYC + 1);

  localparam logic [PH_W-1:0]  INHIBIT_LOAD = PH_W'(INHIBIT_CYC - 1);
  localparam logic [PH_W-1:0]  START_LOAD   = PH_W'(START_CYC - 1);
  localparam logic [TMO_W-1:0] START_TMO    = TMO_W'(START_TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] EDGE_TMO     = TMO_W'(EDGE_TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_ONE      = TMO_W'(1);

  t                  state_q,    state_d;
  logic [9:0]        shift_q,    shift_d;
  logic [3:0]        bitCnt_q,   bitCnt_d;
  logic [PH_W-1:0]   phaseCnt_q, phaseCnt_d;
  logic [TMO_W-1:0]  tmoCnt_q,   tmoCnt_d;
  logic              clkOe_q,    clkOe_d;
  logic              datOe_q,    datOe_d;
  logic              ackBit_q,   ackBit_d;
  logic              done_q,     done_d;
  logic              nack_q,     nack_d;
  logic              timeout_q,  timeout_d;
  logic              abort;

  logic clkSync;
  logic datSync;
  logic clkFall;

  ps2_line_sync uLineSync (
    .clk_i     (CLOCK_50),
    .resetN_i  (reset),
    .ps2Clk_i  (ps2_clk_in),
    .ps2Dat_i  (ps2_dat_in),
    .clkSync_o (clkSync),
    .datSync_o (datSync),
    .clkFall_o (clkFall)
  );

  // Next-state, shift and line-drive logic for one host frame.
  // The timeout counter counts down. Hitting zero is an abort, and a device
  // falling edge reloads the counter before it can expire.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    phaseCnt_d = phaseCnt_q;
    tmoCnt_d   = tmoCnt_q;
    clkOe_d    = clkOe_q;
    datOe_d    = datOe_q;
    ackBit_d   = ackBit_q;
    done_d     = 1'b0;
    nack_d     = 1'b0;
    timeout_d  = 1'b0;
    abort      = 1'b0;

    case (state_q)
      IDLE: begin
        clkOe_d = 1'b0;
        datOe_d = 1'b0;
        if (tx_valid) begin
          state_d    = INHIBIT;
          shift_d    = {1'b1, ~^tx_data, tx_data};
          bitCnt_d   = 4'd0;
          phaseCnt_d = INHIBIT_LOAD;
          clkOe_d    = 1'b1;
        end
      end

      INHIBIT: begin
        if (phaseCnt_q == '0) begin
          state_d    = START;
          phaseCnt_d = START_LOAD;
          datOe_d    = 1'b1;
        end else begin
          phaseCnt_d = phaseCnt_q - PH_W'(1);
        end
      end

      START: begin
        if (phaseCnt_q == '0) begin
          state_d  = TX;
          clkOe_d  = 1'b0;
          tmoCnt_d = START_TMO;
        end else begin
          phaseCnt_d = phaseCnt_q - PH_W'(1);
        end
      end

      TX: begin
        if (clkFall) begin
          datOe_d  = ~shift_q[0];
          shift_d  = {1'b0, shift_q[9:1]};
          bitCnt_d = bitCnt_q + 4'd1;
          tmoCnt_d = EDGE_TMO;
          if (bitCnt_q == 4'd9) begin
            state_d = ACK;
          end
        end else if (tmoCnt_q == TMO_ONE) begin
          abort = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q - TMO_ONE;
        end
      end

      ACK: begin
        if (clkFall) begin
          ackBit_d = datSync;
          state_d  = WAIT_IDLE;
          tmoCnt_d = EDGE_TMO;
        end else if (tmoCnt_q == TMO_ONE) begin
          abort = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q - TMO_ONE;
        end
      end

      WAIT_IDLE: begin
        if (clkSync && datSync) begin
          state_d  = IDLE;
          tmoCnt_d = '0;
          done_d   = ~ackBit_q;
          nack_d   = ackBit_q;
        end else if (tmoCnt_q == TMO_ONE) begin
          abort = 1'b1;
        end else begin
          tmoCnt_d = tmoCnt_q - TMO_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        clkOe_d = 1'b0;
        datOe_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d   = IDLE;
      clkOe_d   = 1'b0;
      datOe_d   = 1'b0;
      tmoCnt_d  = '0;
      timeout_d = 1'b1;
    end
  end

  // State register. Reset clears everything and releases both lines at once.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      phaseCnt_q <= '0;
      tmoCnt_q   <= '0;
      clkOe_q    <= 1'b0;
      datOe_q    <= 1'b0;
      ackBit_q   <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      phaseCnt_q <= phaseCnt_d;
      tmoCnt_q   <= tmoCnt_d;
      clkOe_q    <= clkOe_d;
      datOe_q    <= datOe_d;
      ackBit_q   <= ackBit_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign rx_inhibit = (state_q != IDLE);
  assign tx_done    = done_q;
  assign tx_nack    = nack_q;
  assign tx_timeout = timeout_q;
  assign ps2_clk_oe = clkOe_q;
  assign ps2_dat_oe = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a cycle-based PS/2 device model on
// the open-drain bus. Timers are shrunk through parameters:
// 2 cycles/us, inhibit 240, start 2, start timeout 3000, edge timeout 400.
// The device clock half-period is 40 us, which is 80 cycles.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ           = 2_000_000;
  localparam int unsigned INHIBIT_US       = 120;
  localparam int unsigned START_TIMEOUT_US = 1500;
  localparam int unsigned EDGE_TIMEOUT_US  = 200;

  localparam int HALF = 80;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_nack;
  logic       tx_timeout;
  logic       rx_inhibit;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       devClkLow;
  logic       devDatLow;
  wire        ps2ClkPin = ~(ps2_clk_oe | devClkLow);
  wire        ps2DatPin = ~(ps2_dat_oe | devDatLow);

  int vectors     = 0;
  int miscompares = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .CLK_HZ           (CLK_HZ),
    .INHIBIT_US       (INHIBIT_US),
    .START_TIMEOUT_US (START_TIMEOUT_US),
    .EDGE_TIMEOUT_US  (EDGE_TIMEOUT_US)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_nack    (tx_nack),
    .tx_timeout (tx_timeout),
    .rx_inhibit (rx_inhibit),
    .ps2_clk_in (ps2ClkPin),
    .ps2_dat_in (ps2DatPin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle request pulse. The call returns on the negedge after the accept edge.
  task automatic applyStimulus(input logic [7:0] d);
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  // Device side of one frame. It waits for the host start bit, then issues
  // nEdges clock pulses and samples data on each rising edge.
  task automatic deviceFrame(input int nEdges, input logic ackLow,
                             output logic [9:0] got, output logic startBit);
    int w;
    w        = 0;
    got      = '0;
    startBit = 1'bx;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 20000) begin
      @(negedge CLOCK_50);
      w++;
    end
    checkOutput("dev_wait_start", 32'(w < 20000), 32'd1);
    if (w >= 20000) return;
    repeat (20) @(negedge CLOCK_50);
    startBit = ps2DatPin;
    for (int e = 1; e <= nEdges; e++) begin
      if (e == 11 && ackLow) devDatLow = 1'b1;
      devClkLow = 1'b1;
      repeat (HALF) @(negedge CLOCK_50);
      devClkLow = 1'b0;
      if (e <= 10) got[e-1] = ps2DatPin;
      if (e == 11) begin
        @(negedge CLOCK_50);
        devDatLow = 1'b0;
      end else begin
        repeat (HALF) @(negedge CLOCK_50);
      end
    end
  endtask

  // Bounded wait for the first status pulse. All zeros means none arrived.
  task automatic waitStatus(input int limit, output logic [2:0] status);
    int cyc;
    cyc    = 0;
    status = 3'b000;
    while (cyc < limit) begin
      @(negedge CLOCK_50);
      cyc++;
      if (tx_done || tx_nack || tx_timeout) begin
        status = {tx_done, tx_nack, tx_timeout};
        break;
      end
    end
  endtask

  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [9:0] got;
    logic       sb;
    logic [2:0] st;
    int         cnt;
    int         stCnt;
    int         pulseCnt;

    reset     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    devClkLow = 1'b0;
    devDatLow = 1'b0;

    // Reset state: {ready, inhibit, clk_oe, dat_oe, done, nack, timeout}
    repeat (2) @(negedge CLOCK_50);
    checkOutput("reset_state", 32'({tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe,
                                    tx_done, tx_nack, tx_timeout}), 32'b1000000);
    reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // 0xED with ACK. Inhibit is 240 cycles and start is 2. A request
    // arriving while busy must be ignored.
    applyStimulus(8'hED);
    checkOutput("ed_accept", 32'({tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe}), 32'b0110);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    tx_data  = 8'hA5;
    cnt = 2;
    while (ps2_clk_oe && !ps2_dat_oe && cnt < 10000) begin
      cnt++;
      @(negedge CLOCK_50);
    end
    stCnt = 0;
    while (ps2_clk_oe && ps2_dat_oe && stCnt < 100) begin
      stCnt++;
      @(negedge CLOCK_50);
    end
    checkOutput("ed_inhibit_cycles", 32'(cnt - 1), 32'd240);
    checkOutput("ed_start_cycles", 32'(stCnt), 32'd2);
    deviceFrame(11, 1'b1, got, sb);
    checkOutput("ed_start_bit", 32'(sb), 32'd0);
    checkOutput("ed_bits", 32'(got), 32'h3ED);
    waitStatus(50, st);
    checkOutput("ed_status", 32'({st, tx_ready}), 32'b1001);
    @(negedge CLOCK_50);
    checkOutput("ed_pulse_width", 32'({tx_done, tx_nack, tx_timeout}), 32'b000);

    // 0x01 with the device leaving the ACK bit high: parity 0, then NACK.
    applyStimulus(8'h01);
    deviceFrame(11, 1'b0, got, sb);
    checkOutput("nack_bits", 32'(got), 32'h201);
    waitStatus(50, st);
    checkOutput("nack_status", 32'(st), 32'b010);

    // The device never clocks, so a timeout comes 3000 cycles after START ends.
    applyStimulus(8'h3C);
    cnt = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && cnt < 1000) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    cnt = 0;
    while (!tx_timeout && cnt < 5000) begin
      @(negedge CLOCK_50);
      cnt++;
    end
    checkOutput("start_tmo_cycles", 32'(cnt), 32'd3000);
    checkOutput("start_tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, tx_done, tx_nack}),
                32'b00100);

    // The device stops after edge 5. The edge is seen 3 cycles after the pin
    // falls, and the 400-cycle edge timeout runs from there.
    applyStimulus(8'hF4);
    deviceFrame(4, 1'b0, got, sb);
    checkOutput("stall_bits", 32'(got[3:0]), 32'h4);
    devClkLow = 1'b1;
    cnt = 0;
    while (!tx_timeout && cnt < 5000) begin
      @(negedge CLOCK_50);
      cnt++;
      if (cnt == HALF) devClkLow = 1'b0;
    end
    checkOutput("edge_tmo_cycles", 32'(cnt), 32'd403);
    checkOutput("edge_tmo_lines", 32'({ps2_clk_oe, ps2_dat_oe, tx_done, tx_nack}), 32'b0000);

    // Reset asserted mid-frame after edge 4 of 0x55, while bit3=0 is driven.
    applyStimulus(8'h55);
    deviceFrame(4, 1'b0, got, sb);
    checkOutput("rst_mid_frame", 32'({ps2_dat_oe, tx_ready}), 32'b10);
    reset = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("rst_release", 32'({ps2_clk_oe, ps2_dat_oe, tx_ready, rx_inhibit,
                                    tx_done, tx_nack, tx_timeout}), 32'b0010000);
    reset = 1'b1;
    pulseCnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      if (tx_done || tx_nack || tx_timeout) pulseCnt++;
    end
    checkOutput("rst_no_pulse", 32'(pulseCnt), 32'd0);
    applyStimulus(8'hF4);
    deviceFrame(11, 1'b1, got, sb);
    checkOutput("f4_bits", 32'(got), 32'h2F4);
    waitStatus(50, st);
    checkOutput("f4_status", 32'(st), 32'b100);

    // tx_valid held high: 0xFF, then 0xF4 accepted in the done cycle.
    @(negedge CLOCK_50);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    checkOutput("b2b_first_accept", 32'(tx_ready), 32'd0);
    tx_data = 8'hF4;
    deviceFrame(11, 1'b1, got, sb);
    checkOutput("b2b_ff_bits", 32'(got), 32'h3FF);
    waitStatus(50, st);
    checkOutput("b2b_done_cycle", 32'({st, tx_ready, rx_inhibit}), 32'b10010);
    @(negedge CLOCK_50);
    checkOutput("b2b_second_accept", 32'({tx_ready, rx_inhibit}), 32'b01);
    tx_valid = 1'b0;
    deviceFrame(11, 1'b1, got, sb);
    checkOutput("b2b_f4_bits", 32'(got), 32'h2F4);
    waitStatus(50, st);
    checkOutput("b2b_f4_status", 32'(st), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
